vga_sync_gen: RTL and testbench

- Generates 640x480 @ 60 Hz VGA timing from the 100 MHz board clock.
- Sits directly upstream of the pixel generation stage and drives its x, y and video_on inputs.
- Drives hsync/vsync to the VGA connector and provides a pixel-rate enable plus line/frame pulses for downstream logic.

---
 rtl/vga_timing_pkg.sv | 44 ++++
 rtl/pixel_tick_div.sv | 36 +++
 rtl/vga_sync_gen.sv | 110 +++++++++++
 tb/tb_vga_sync_gen.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480 @ 60 Hz timing constants and small helpers.
// Used by the sync generator and by the pixel generation stage (X_MAX/Y_MAX).
package vga_timing_pkg;

    // Width of the x / y counters handed to downstream logic
    localparam int COUNT_W = 10;

    typedef logic [COUNT_W-1:0] count_t;

    // Horizontal timing, in pixels
    localparam int VGA_H_DISPLAY = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_H_RETRACE = 96;
    localparam int VGA_H_TOTAL   = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_BACK + VGA_H_RETRACE;

    // Vertical timing, in lines
    localparam int VGA_V_DISPLAY = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_BACK    = 33;
    localparam int VGA_V_RETRACE = 2;
    localparam int VGA_V_TOTAL   = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_BACK + VGA_V_RETRACE;

    // Board clock cycles per pixel (100 MHz -> 25 MHz)
    localparam int VGA_CLK_DIV   = 4;

    // Largest values the counters ever reach
    localparam int VGA_X_MAX     = VGA_H_TOTAL - 1;
    localparam int VGA_Y_MAX     = VGA_V_TOTAL - 1;

    // Both sync pulses are active-low for this mode
    localparam logic SYNC_ACTIVE = 1'b0;

    // Sync pin level for a given "inside retrace" condition
    function automatic logic sync_level(input logic active);
        return active ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    endfunction

    // Inclusive window test on a counter value
    function automatic logic in_window(input count_t value, input count_t lo, input count_t hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Divides the board clock down to a one-cycle pixel enable.
// p_tick is decoded straight from the divider register, so it is low in reset.
module pixel_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] div_next;

    // Free-running 0..CLK_DIV-1 count, wrapping on the terminal value
    always_comb begin
        div_next = div_reg + DIV_W'(1);
        if (div_reg == DIV_MAX) begin
            div_next = '0;
        end
    end

    // Divider register, cleared by the active-low synchronous reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_reg <= '0;
        end else begin
            div_reg <= div_next;
        end
    end

    assign p_tick = (div_reg == DIV_MAX);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: pixel/line counters, sync pulses and line/frame strobes.
// Sync outputs are registered from the next count so they move on the same
// edge as x / y; video_on is decoded from the registered counts.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY = VGA_H_DISPLAY,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int H_RETRACE = VGA_H_RETRACE,
    parameter int V_DISPLAY = VGA_V_DISPLAY,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_BACK    = VGA_V_BACK,
    parameter int V_RETRACE = VGA_V_RETRACE,
    parameter int CLK_DIV   = VGA_CLK_DIV
) (
    input  logic               clk,
    input  logic               reset,
    output logic               p_tick,
    output logic [COUNT_W-1:0] x,
    output logic [COUNT_W-1:0] y,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync,
    output logic               line_tick,
    output logic               frame_tick
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_BACK + H_RETRACE;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_BACK + V_RETRACE;

    localparam count_t H_MAX    = count_t'(H_TOTAL - 1);
    localparam count_t V_MAX    = count_t'(V_TOTAL - 1);
    localparam count_t H_VIS    = count_t'(H_DISPLAY);
    localparam count_t V_VIS    = count_t'(V_DISPLAY);
    localparam count_t HS_START = count_t'(H_DISPLAY + H_FRONT);
    localparam count_t HS_END   = count_t'(H_DISPLAY + H_FRONT + H_RETRACE - 1);
    localparam count_t VS_START = count_t'(V_DISPLAY + V_FRONT);
    localparam count_t VS_END   = count_t'(V_DISPLAY + V_FRONT + V_RETRACE - 1);

    logic   pix_tick;
    count_t h_count_reg;
    count_t h_count_next;
    count_t v_count_reg;
    count_t v_count_next;
    logic   h_wrap;
    logic   v_wrap;
    logic   hsync_reg;
    logic   vsync_reg;
    logic   line_tick_reg;
    logic   frame_tick_reg;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick_div (
        .clk    (clk),
        .reset  (reset),
        .p_tick (pix_tick)
    );

    // Next-count logic: x steps on every pixel enable, y only when x wraps
    always_comb begin
        h_wrap       = pix_tick && (h_count_reg == H_MAX);
        v_wrap       = h_wrap && (v_count_reg == V_MAX);
        h_count_next = h_count_reg;
        v_count_next = v_count_reg;
        if (pix_tick) begin
            h_count_next = h_wrap ? '0 : h_count_reg + count_t'(1);
        end
        if (h_wrap) begin
            v_count_next = v_wrap ? '0 : v_count_reg + count_t'(1);
        end
    end

    // Counter registers; a reset anywhere in the frame restarts at the origin
    always_ff @(posedge clk) begin
        if (!reset) begin
            h_count_reg <= '0;
            v_count_reg <= '0;
        end else begin
            h_count_reg <= h_count_next;
            v_count_reg <= v_count_next;
        end
    end

    // Sync pulses and line/frame strobes, aligned with the counter update
    always_ff @(posedge clk) begin
        if (!reset) begin
            hsync_reg      <= ~SYNC_ACTIVE;
            vsync_reg      <= ~SYNC_ACTIVE;
            line_tick_reg  <= 1'b0;
            frame_tick_reg <= 1'b0;
        end else begin
            hsync_reg      <= sync_level(in_window(h_count_next, HS_START, HS_END));
            vsync_reg      <= sync_level(in_window(v_count_next, VS_START, VS_END));
            line_tick_reg  <= h_wrap;
            frame_tick_reg <= v_wrap;
        end
    end

    assign p_tick     = pix_tick;
    assign x          = h_count_reg;
    assign y          = v_count_reg;
    assign video_on   = (h_count_reg < H_VIS) && (v_count_reg < V_VIS);
    assign hsync      = hsync_reg;
    assign vsync      = vsync_reg;
    assign line_tick  = line_tick_reg;
    assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen.
// Instance A uses the real 640x480 timing (reset, pixel enable, one line,
// mid-frame reset). Instance B uses a shrunken raster so whole frames fit in
// a short run (vertical timing, frame strobe, bounds over two frames).
// Expected outputs come from a closed-form model of elapsed clock edges.
module tb_vga_sync_gen;

    typedef struct packed {
        logic       p_tick;
        logic [9:0] x;
        logic [9:0] y;
        logic       video_on;
        logic       hsync;
        logic       vsync;
        logic       line_tick;
        logic       frame_tick;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a, reset_b;
    logic       p_tick_a, video_on_a, hsync_a, vsync_a, line_tick_a, frame_tick_a;
    logic [9:0] x_a, y_a;
    logic       p_tick_b, video_on_b, hsync_b, vsync_b, line_tick_b, frame_tick_b;
    logic [9:0] x_b, y_b;
    obs_t       obs_a, obs_b;

    vga_sync_gen dut_a (
        .clk        (clk),
        .reset      (reset_a),
        .p_tick     (p_tick_a),
        .x          (x_a),
        .y          (y_a),
        .video_on   (video_on_a),
        .hsync      (hsync_a),
        .vsync      (vsync_a),
        .line_tick  (line_tick_a),
        .frame_tick (frame_tick_a)
    );

    vga_sync_gen #(
        .H_DISPLAY (16), .H_FRONT (4), .H_BACK (6), .H_RETRACE (8),
        .V_DISPLAY (12), .V_FRONT (2), .V_BACK (3), .V_RETRACE (2),
        .CLK_DIV   (4)
    ) dut_b (
        .clk        (clk),
        .reset      (reset_b),
        .p_tick     (p_tick_b),
        .x          (x_b),
        .y          (y_b),
        .video_on   (video_on_b),
        .hsync      (hsync_b),
        .vsync      (vsync_b),
        .line_tick  (line_tick_b),
        .frame_tick (frame_tick_b)
    );

    assign obs_a = {p_tick_a, x_a, y_a, video_on_a, hsync_a, vsync_a, line_tick_a, frame_tick_a};
    assign obs_b = {p_tick_b, x_b, y_b, video_on_b, hsync_b, vsync_b, line_tick_b, frame_tick_b};

    localparam int FRAME_B = 34 * 19 * 4;

    int   tests_run    = 0;
    int   tests_failed = 0;
    int   e_a = 0;
    int   e_b = 0;
    obs_t sb_a[$];
    obs_t sb_b[$];

    // Expected outputs after e clock edges since reset release (e = 0: in reset)
    function automatic obs_t model(input int e, input int hd, input int hf, input int hb,
                                   input int hr, input int vd, input int vf, input int vb,
                                   input int vr);
        obs_t o;
        int ht, vt, p, xi, yi;
        ht = hd + hf + hb + hr;
        vt = vd + vf + vb + vr;
        p  = e / 4;
        xi = p % ht;
        yi = (p / ht) % vt;
        o.p_tick     = (e % 4) == 3;
        o.x          = 10'(xi);
        o.y          = 10'(yi);
        o.video_on   = (xi < hd) && (yi < vd);
        o.hsync      = !((xi >= hd + hf) && (xi < hd + hf + hr));
        o.vsync      = !((yi >= vd + vf) && (yi < vd + vf + vr));
        o.line_tick  = (e > 0) && ((e % 4) == 0) && (xi == 0);
        o.frame_tick = o.line_tick && (yi == 0);
        return o;
    endfunction

    // Advance instance A one clock and queue what it should show afterwards
    task automatic tick_a();
        @(posedge clk);
        e_a = (reset_a === 1'b0) ? 0 : e_a + 1;
        sb_a.push_back(model(e_a, 640, 16, 48, 96, 480, 10, 33, 2));
        @(negedge clk);
    endtask

    // Advance instance B one clock and queue what it should show afterwards
    task automatic tick_b();
        @(posedge clk);
        e_b = (reset_b === 1'b0) ? 0 : e_b + 1;
        sb_b.push_back(model(e_b, 16, 4, 6, 8, 12, 2, 3, 2));
        @(negedge clk);
    endtask

    task automatic test_reset();
        obs_t want;
        reset_a = 1'b0;
        repeat (5) begin
            tick_a();
            want = sb_a.pop_front();
            tests_run++;
            if (obs_a !== want) begin
                tests_failed++;
                $display("FAIL reset_state: got %b required %b", obs_a, want);
            end
        end
        tests_run++;
        if (x_a !== 10'd0 || y_a !== 10'd0 || hsync_a !== 1'b1 || vsync_a !== 1'b1 ||
            video_on_a !== 1'b1 || p_tick_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_values: got x=%0d y=%0d hs=%b vs=%b von=%b pt=%b required 0 0 1 1 1 0",
                     x_a, y_a, hsync_a, vsync_a, video_on_a, p_tick_a);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_pixel_enable();
        obs_t want;
        int   ticks;
        ticks   = 0;
        reset_a = 1'b1;
        repeat (16) begin
            tick_a();
            want = sb_a.pop_front();
            tests_run++;
            if (obs_a !== want) begin
                tests_failed++;
                $display("FAIL pixel_enable e=%0d: got %b required %b", e_a, obs_a, want);
            end
            if (p_tick_a === 1'b1) ticks++;
            if (e_a == 4 || e_a == 8) begin
                tests_run++;
                if (x_a !== 10'(e_a / 4)) begin
                    tests_failed++;
                    $display("FAIL pixel_x_step e=%0d: got x=%0d required %0d", e_a, x_a, e_a / 4);
                end
            end
        end
        tests_run++;
        if (ticks != 4) begin
            tests_failed++;
            $display("FAIL pixel_tick_count: got %0d required 4", ticks);
        end
        $display("[TB] test_pixel_enable done, %0d p_ticks", ticks);
    endtask

    task automatic test_horizontal();
        obs_t want;
        logic prev_hs, prev_vo;
        int   lines, falls;
        prev_hs = hsync_a;
        prev_vo = video_on_a;
        lines   = 0;
        falls   = 0;
        while (e_a < 3240) begin
            tick_a();
            want = sb_a.pop_front();
            tests_run++;
            if (obs_a !== want) begin
                tests_failed++;
                $display("FAIL horiz_cycle e=%0d: got %b required %b", e_a, obs_a, want);
            end
            if (prev_hs === 1'b1 && hsync_a === 1'b0) begin
                falls++;
                tests_run++;
                if (x_a !== 10'd656) begin
                    tests_failed++;
                    $display("FAIL hsync_fall: got x=%0d required 656", x_a);
                end
            end
            if (prev_hs === 1'b0 && hsync_a === 1'b1) begin
                tests_run++;
                if (x_a !== 10'd752) begin
                    tests_failed++;
                    $display("FAIL hsync_rise: got x=%0d required 752", x_a);
                end
            end
            if (prev_vo === 1'b1 && video_on_a === 1'b0) begin
                tests_run++;
                if (x_a !== 10'd640) begin
                    tests_failed++;
                    $display("FAIL video_on_fall: got x=%0d required 640", x_a);
                end
            end
            if (line_tick_a === 1'b1) begin
                lines++;
                tests_run++;
                if (x_a !== 10'd0 || y_a !== 10'd1 || e_a != 3200) begin
                    tests_failed++;
                    $display("FAIL line_tick_pos: got x=%0d y=%0d e=%0d required 0 1 3200", x_a, y_a, e_a);
                end
            end
            prev_hs = hsync_a;
            prev_vo = video_on_a;
        end
        tests_run++;
        if (lines != 1 || falls != 1) begin
            tests_failed++;
            $display("FAIL line_event_count: got lines=%0d hs_falls=%0d required 1 1", lines, falls);
        end
        $display("[TB] test_horizontal done, %0d line_ticks", lines);
    endtask

    task automatic test_mid_frame_reset();
        obs_t want;
        // Instance A: restart, run to x=700 (inside hsync), then reset
        reset_a = 1'b0;
        tick_a();
        void'(sb_a.pop_front());
        reset_a = 1'b1;
        while (e_a < 2801) begin
            tick_a();
            want = sb_a.pop_front();
            tests_run++;
            if (obs_a !== want) begin
                tests_failed++;
                $display("FAIL mid_run_a e=%0d: got %b required %b", e_a, obs_a, want);
            end
        end
        reset_a = 1'b0;
        tick_a();
        want = sb_a.pop_front();
        tests_run++;
        if (obs_a !== want || x_a !== 10'd0 || y_a !== 10'd0 || hsync_a !== 1'b1 || vsync_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_reset_a: got %b required %b", obs_a, want);
        end
        reset_a = 1'b1;
        repeat (40) begin
            tick_a();
            want = sb_a.pop_front();
            tests_run++;
            if (obs_a !== want) begin
                tests_failed++;
                $display("FAIL restart_a e=%0d: got %b required %b", e_a, obs_a, want);
            end
        end
        reset_a = 1'b0;
        // Instance B: run to x=20, y=10 (inside hsync), then reset
        reset_b = 1'b0;
        tick_b();
        void'(sb_b.pop_front());
        reset_b = 1'b1;
        while (e_b < 1441) begin
            tick_b();
            want = sb_b.pop_front();
            tests_run++;
            if (obs_b !== want) begin
                tests_failed++;
                $display("FAIL mid_run_b e=%0d: got %b required %b", e_b, obs_b, want);
            end
        end
        reset_b = 1'b0;
        tick_b();
        want = sb_b.pop_front();
        tests_run++;
        if (obs_b !== want || x_b !== 10'd0 || y_b !== 10'd0 || hsync_b !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_reset_b: got %b required %b", obs_b, want);
        end
        reset_b = 1'b1;
        repeat (40) begin
            tick_b();
            want = sb_b.pop_front();
            tests_run++;
            if (obs_b !== want) begin
                tests_failed++;
                $display("FAIL restart_b e=%0d: got %b required %b", e_b, obs_b, want);
            end
        end
        $display("[TB] test_mid_frame_reset done");
    endtask

    task automatic test_vertical();
        obs_t want;
        int   frames, vs_low;
        frames  = 0;
        vs_low  = 0;
        reset_b = 1'b0;
        repeat (2) begin
            tick_b();
            void'(sb_b.pop_front());
        end
        reset_b = 1'b1;
        while (e_b < FRAME_B + 8) begin
            tick_b();
            want = sb_b.pop_front();
            tests_run++;
            if (obs_b !== want) begin
                tests_failed++;
                $display("FAIL vert_cycle e=%0d: got %b required %b", e_b, obs_b, want);
            end
            if (vsync_b === 1'b0) vs_low++;
            tests_run++;
            if ((vsync_b === 1'b0 && (y_b < 10'd14 || y_b > 10'd15)) ||
                (video_on_b === 1'b1 && y_b >= 10'd12)) begin
                tests_failed++;
                $display("FAIL vert_window: got y=%0d vs=%b von=%b", y_b, vsync_b, video_on_b);
            end
            if (frame_tick_b === 1'b1) begin
                frames++;
                tests_run++;
                if (line_tick_b !== 1'b1 || e_b != FRAME_B) begin
                    tests_failed++;
                    $display("FAIL frame_tick_pos: got e=%0d lt=%b required e=%0d lt=1", e_b, line_tick_b, FRAME_B);
                end
            end
        end
        tests_run++;
        if (frames != 1 || vs_low != 2 * 34 * 4) begin
            tests_failed++;
            $display("FAIL vert_counts: got frames=%0d vs_low=%0d required 1 %0d", frames, vs_low, 2 * 34 * 4);
        end
        $display("[TB] test_vertical done, %0d frame_ticks", frames);
    endtask

    task automatic test_bounds();
        obs_t want;
        int   frames, lines;
        frames  = 0;
        lines   = 0;
        reset_b = 1'b0;
        tick_b();
        void'(sb_b.pop_front());
        reset_b = 1'b1;
        while (e_b < 2 * FRAME_B) begin
            tick_b();
            want = sb_b.pop_front();
            tests_run++;
            if (obs_b !== want || x_b > 10'd33 || y_b > 10'd18) begin
                tests_failed++;
                $display("FAIL bounds e=%0d: got %b required %b", e_b, obs_b, want);
            end
            if (line_tick_b === 1'b1) lines++;
            if (frame_tick_b === 1'b1) frames++;
        end
        tests_run++;
        if (frames != 2 || lines != 2 * 19) begin
            tests_failed++;
            $display("FAIL tick_totals: got frames=%0d lines=%0d required 2 %0d", frames, lines, 2 * 19);
        end
        $display("[TB] test_bounds done, %0d frame_ticks %0d line_ticks", frames, lines);
    endtask

    initial begin
        reset_a = 1'b0;
        reset_b = 1'b0;
        test_reset();
        test_pixel_enable();
        test_horizontal();
        test_mid_frame_reset();
        test_vertical();
        test_bounds();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
